// File: rtl/cache_flush_ctrl.sv
// cache_flush_ctrl: walks every data-cache line after a CSR flush request,
// writing back valid+dirty lines over a req/ack handshake, invalidating each
// line, stalling the core for the whole sweep and pulsing flush_done at the end.
//
// Ports:
//   clk, rst_n   - clock, asynchronous active-low reset
//   flush_req    - one-cycle flush flag from the CSR file
//   line_idx     - index of the line currently examined (registered)
//   line_valid   - valid bit of line line_idx (combinational from cache)
//   line_dirty   - dirty bit of line line_idx (combinational from cache)
//   wb_req       - write-back request for line line_idx
//   wb_ack       - write-back completed
//   inv_line     - one-cycle strobe clearing valid/dirty of line line_idx
//   stall, busy  - sweep in progress
//   flush_done   - one-cycle pulse at end of sweep
//   wb_count     - lines written back in the current or last sweep
module cache_flush_ctrl #(
  parameter int unsigned NUM_LINES = 8,
  parameter int unsigned IDX_W     = $clog2(NUM_LINES)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush_req,
  output logic [IDX_W-1:0] line_idx,
  input  logic             line_valid,
  input  logic             line_dirty,
  output logic             wb_req,
  input  logic             wb_ack,
  output logic             inv_line,
  output logic             stall,
  output logic             busy,
  output logic             flush_done,
  output logic [15:0]      wb_count
);

  localparam int unsigned CNT_W = 16;

  typedef enum logic [2:0] {
    IDLE,
    CHECK,
    WRITEBACK,
    INVAL,
    DONE
  } state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               pending_q, pending_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  // Next-state, index, pending and write-back counter logic.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    pending_d = pending_q;
    cnt_d     = cnt_q;

    // Requests arriving mid-sweep collapse into a single pending flush.
    if (state_q != IDLE && flush_req) begin
      pending_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (flush_req) begin
          idx_d     = '0;
          cnt_d     = '0;
          pending_d = 1'b0;
          state_d   = CHECK;
        end
      end
      CHECK: begin
        state_d = (line_valid && line_dirty) ? WRITEBACK : INVAL;
      end
      WRITEBACK: begin
        if (wb_ack) begin
          cnt_d   = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);
          state_d = INVAL;
        end
      end
      INVAL: begin
        if (idx_q == IDX_W'(NUM_LINES - 1)) begin
          state_d = DONE;
        end else begin
          idx_d   = idx_q + IDX_W'(1);
          state_d = CHECK;
        end
      end
      DONE: begin
        // A request in this very cycle also chains straight into a new sweep.
        if (pending_q || flush_req) begin
          pending_d = 1'b0;
          idx_d     = '0;
          cnt_d     = '0;
          state_d   = CHECK;
        end else begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and registered outputs; outputs track the state being entered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      pending_q  <= 1'b0;
      cnt_q      <= '0;
      wb_req     <= 1'b0;
      inv_line   <= 1'b0;
      stall      <= 1'b0;
      busy       <= 1'b0;
      flush_done <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      pending_q  <= pending_d;
      cnt_q      <= cnt_d;
      wb_req     <= (state_d == WRITEBACK);
      inv_line   <= (state_d == INVAL);
      stall      <= (state_d != IDLE);
      busy       <= (state_d != IDLE);
      flush_done <= (state_d == DONE);
    end
  end

  assign line_idx = idx_q;
  assign wb_count = cnt_q;

endmodule

// File: tb/tb_cache_flush_ctrl.sv
// Directed testbench for cache_flush_ctrl with a small line-status model
// and a programmable-latency write-back acknowledger.
module tb_cache_flush_ctrl;

  localparam int unsigned N     = 8;
  localparam int unsigned IDX_W = 3;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             flush_req;
  logic [IDX_W-1:0] line_idx;
  logic             line_valid;
  logic             line_dirty;
  logic             wb_req;
  logic             wb_ack;
  logic             inv_line;
  logic             stall;
  logic             busy;
  logic             flush_done;
  logic [15:0]      wb_count;

  logic v_mem [N];
  logic d_mem [N];

  assign line_valid = v_mem[line_idx];
  assign line_dirty = d_mem[line_idx];

  cache_flush_ctrl #(.NUM_LINES(N)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush_req  (flush_req),
    .line_idx   (line_idx),
    .line_valid (line_valid),
    .line_dirty (line_dirty),
    .wb_req     (wb_req),
    .wb_ack     (wb_ack),
    .inv_line   (inv_line),
    .stall      (stall),
    .busy       (busy),
    .flush_done (flush_done),
    .wb_count   (wb_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Per-sweep observations
  int done_c1, done_c2, inv_cnt, inv_bad, stall_end, busy_bad, wbreq_total;
  int wbreq_cyc [N];

  task automatic set_lines(input logic v, input logic d);
    for (int i = 0; i < int'(N); i++) begin
      v_mem[i] = v;
      d_mem[i] = d;
    end
  endtask

  // Pulse flush_req in cycle 0, then observe cycles 1..ncyc at the falling edge.
  // wb_ack is raised in the (d+1)-th cycle of each wb_req burst.
  task automatic sweep(input int d, input int ncyc, input int pulse_c);
    int wb_wait;
    wb_wait = 0;
    done_c1 = 0; done_c2 = 0; inv_cnt = 0; inv_bad = 0;
    stall_end = 0; busy_bad = 0; wbreq_total = 0;
    for (int i = 0; i < int'(N); i++) wbreq_cyc[i] = 0;
    @(negedge clk);
    flush_req = 1'b1;
    for (int c = 1; c <= ncyc; c++) begin
      @(negedge clk);
      flush_req = (c == pulse_c);
      if (flush_done) begin
        if (done_c1 == 0) done_c1 = c;
        else if (done_c2 == 0) done_c2 = c;
      end
      if (!stall && stall_end == 0) stall_end = c;
      if (busy !== stall) busy_bad++;
      if (inv_line) begin
        if (line_idx != IDX_W'(inv_cnt % int'(N))) inv_bad++;
        inv_cnt++;
        v_mem[line_idx] = 1'b0;
        d_mem[line_idx] = 1'b0;
      end
      if (wb_req) begin
        wbreq_cyc[line_idx]++;
        wbreq_total++;
        wb_wait++;
        wb_ack = (wb_wait == d + 1);
      end else begin
        wb_wait = 0;
        wb_ack  = 1'b0;
      end
    end
    wb_ack    = 1'b0;
    flush_req = 1'b0;
  endtask

  initial begin
    int found;
    int stall_seen;
    rst_n     = 1'b0;
    flush_req = 1'b0;
    wb_ack    = 1'b0;
    set_lines(1'b0, 1'b0);

    // Reset state
    @(negedge clk);
    check("rst_stall", 32'(stall), 32'd0);
    check("rst_wb_req", 32'(wb_req), 32'd0);
    check("rst_idx", 32'(line_idx), 32'd0);
    check("rst_done", 32'(flush_done), 32'd0);
    check("rst_count", 32'(wb_count), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // 1: all lines valid and clean
    set_lines(1'b1, 1'b0);
    sweep(0, 20, -1);
    check("t1_done_cyc", 32'(done_c1), 32'd17);
    check("t1_done_once", 32'(done_c2), 32'd0);
    check("t1_inv_cnt", 32'(inv_cnt), 32'd8);
    check("t1_inv_order", 32'(inv_bad), 32'd0);
    check("t1_stall_end", 32'(stall_end), 32'd18);
    check("t1_busy_eq", 32'(busy_bad), 32'd0);
    check("t1_wbreq", 32'(wbreq_total), 32'd0);
    check("t1_count", 32'(wb_count), 32'd0);

    // 2: lines 2 and 5 dirty, ack after 3 wait cycles
    set_lines(1'b1, 1'b0);
    d_mem[2] = 1'b1;
    d_mem[5] = 1'b1;
    sweep(3, 28, -1);
    check("t2_done_cyc", 32'(done_c1), 32'd25);
    check("t2_wbreq_2", 32'(wbreq_cyc[2]), 32'd4);
    check("t2_wbreq_5", 32'(wbreq_cyc[5]), 32'd4);
    check("t2_wbreq_tot", 32'(wbreq_total), 32'd8);
    check("t2_inv_cnt", 32'(inv_cnt), 32'd8);
    check("t2_stall_end", 32'(stall_end), 32'd26);
    check("t2_count", 32'(wb_count), 32'd2);

    // 3: line 3 valid clean, line 4 dirty but invalid, line 6 dirty with d=0
    set_lines(1'b0, 1'b0);
    v_mem[3] = 1'b1;
    v_mem[4] = 1'b0;
    d_mem[4] = 1'b1;
    v_mem[6] = 1'b1;
    d_mem[6] = 1'b1;
    sweep(0, 21, -1);
    check("t3_done_cyc", 32'(done_c1), 32'd18);
    check("t3_wbreq_6", 32'(wbreq_cyc[6]), 32'd1);
    check("t3_wbreq_tot", 32'(wbreq_total), 32'd1);
    check("t3_inv_order", 32'(inv_bad), 32'd0);
    check("t3_count", 32'(wb_count), 32'd1);

    // Spurious ack while idle: no effect, count held from last sweep
    wb_ack = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_ack_stall", 32'(stall), 32'd0);
    check("idle_ack_wbreq", 32'(wb_req), 32'd0);
    check("idle_ack_count", 32'(wb_count), 32'd1);
    wb_ack = 1'b0;
    @(negedge clk);

    // 4: second request in cycle 5 chains a new sweep with no idle gap
    set_lines(1'b1, 1'b0);
    sweep(0, 38, 5);
    check("t4_done1", 32'(done_c1), 32'd17);
    check("t4_done2", 32'(done_c2), 32'd34);
    check("t4_stall_end", 32'(stall_end), 32'd35);
    check("t4_inv_cnt", 32'(inv_cnt), 32'd16);
    check("t4_inv_order", 32'(inv_bad), 32'd0);
    check("t4_count", 32'(wb_count), 32'd0);

    // 5: reset while writing back line 2 (line 0 written back first)
    set_lines(1'b1, 1'b0);
    d_mem[0] = 1'b1;
    d_mem[2] = 1'b1;
    found = 0;
    @(negedge clk);
    flush_req = 1'b1;
    for (int c = 1; c <= 30 && found == 0; c++) begin
      @(negedge clk);
      flush_req = 1'b0;
      if (inv_line) begin
        v_mem[line_idx] = 1'b0;
        d_mem[line_idx] = 1'b0;
      end
      if (wb_req && line_idx == IDX_W'(2)) found = 1;
      wb_ack = wb_req && (line_idx == IDX_W'(0));
    end
    wb_ack = 1'b0;
    check("t5_reach_wb2", 32'(found), 32'd1);
    check("t5_count_pre", 32'(wb_count), 32'd1);
    rst_n = 1'b0;
    #1;
    check("t5_rst_wbreq", 32'(wb_req), 32'd0);
    check("t5_rst_stall", 32'(stall), 32'd0);
    check("t5_rst_busy", 32'(busy), 32'd0);
    check("t5_rst_idx", 32'(line_idx), 32'd0);
    check("t5_rst_count", 32'(wb_count), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    stall_seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (stall || wb_req || inv_line) stall_seen++;
    end
    check("t5_stay_idle", 32'(stall_seen), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global time bound
  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/cache_flush_ctrl.md
# cache_flush_ctrl

Sequencer that turns the one-cycle cache-flush flag from the CSR file (CSR 0x7C0, bit 0) into a full write-back-and-invalidate sweep of the data cache. It walks every line index and issues a write-back request for each valid and dirty line, waiting on a req/ack handshake. It then invalidates the line, stalls the core for the whole sweep, and pulses a completion flag. It sits between the CSR file and the data cache's line-status and write-back ports.

## Interface
Parameters:
- NUM_LINES, 8, number of cache lines to sweep; a power of two, at least 2
- IDX_W, $clog2(NUM_LINES), line index width (derived)

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low
- flush_req  in  1  flush request; connected to CSR flush_cache_flag; sampled every rising edge
- line_idx  out  IDX_W  index of the line currently being examined
- line_valid  in  1  valid bit of line `line_idx`; combinational from the cache
- line_dirty  in  1  dirty bit of line `line_idx`; combinational from the cache
- wb_req  out  1  write-back request for line `line_idx`
- wb_ack  in  1  cache/AXI side has completed the write-back
- inv_line  out  1  one-cycle strobe: clear valid and dirty of line `line_idx`
- stall  out  1  freezes the core pipeline while a sweep is in progress
- busy  out  1  sweep in progress; same as stall
- flush_done  out  1  one-cycle pulse at the end of a sweep
- wb_count  out  16  number of lines written back in the current or last sweep

## Operation
- FSM states: IDLE, CHECK, WRITEBACK, INVAL, DONE.
- IDLE:
  - On flush_req=1: clear the index, clear wb_count and pending, and go to CHECK.
- CHECK:
  - If line_valid & line_dirty: go to WRITEBACK.
  - Otherwise (clean line, or dirty but invalid line): go to INVAL.
- WRITEBACK:
  - wb_req=1 for as long as the FSM stays here.
  - On wb_ack=1: wb_count is incremented (saturating at 0xFFFF) and the FSM goes to INVAL.
  - wb_ack may arrive in the first WRITEBACK cycle.
- INVAL:
  - inv_line=1 for exactly one cycle.
  - If the index equals NUM_LINES-1: go to DONE.
  - Otherwise: increment the index and go to CHECK.
- DONE:
  - flush_done=1 for one cycle.
  - If pending=1: clear pending and the index, clear wb_count, and go to CHECK (a new sweep).
  - Otherwise: go to IDLE.
- flush_req=1 in any non-IDLE state sets pending. Multiple requests collapse into one pending flush.
- wb_ack outside WRITEBACK is ignored.
- The index never wraps mid-sweep; it is reset to 0 only at sweep start.
- Outputs are decoded from state: stall = busy = (state != IDLE); wb_req = (state == WRITEBACK); inv_line = (state == INVAL); flush_done = (state == DONE).
- line_idx is a registered index counter.

## Timing
- Reset (asynchronous, takes effect immediately, mid-sweep included):
  - state = IDLE, index = 0, pending = 0, wb_count = 0.
  - All outputs 0: line_idx = 0, wb_req = 0, inv_line = 0, stall = 0, busy = 0, flush_done = 0.
  - An outstanding write-back is abandoned; wb_req drops with reset.
- Cycle numbering: flush_req is high in cycle 0 and sampled at the end of that cycle. CHECK of line 0 is cycle 1. stall rises in cycle 1.
- Per-line cost:
  - Clean line: 2 cycles (CHECK, INVAL).
  - Dirty line: 3 + d cycles, where d is the number of wait cycles before wb_ack; d = 0 when ack comes in the first WRITEBACK cycle.
- All-clean sweep: flush_done is high in cycle 2·NUM_LINES+1. stall is high in cycles 1..2·NUM_LINES+1. The FSM is back in IDLE in cycle 2·NUM_LINES+2.
- flush_req in the DONE cycle sets pending, so the next sweep starts directly. There are no idle cycles between sweeps; stall stays high.
- wb_count updates on the edge that sees wb_ack and holds its value after DONE until the next sweep starts.

## Test plan
- NUM_LINES=8, all lines clean, single flush_req pulse -> 8 inv_line strobes on indices 0..7; wb_req never asserted; flush_done in cycle 17; stall high in cycles 1-17; wb_count=0.
- Lines 2 and 5 valid+dirty, wb_ack 3 cycles after wb_req rises (d=3) -> wb_req only on idx 2 and 5, each held for 4 cycles; flush_done in cycle 25; wb_count=2.
- Line 3 valid and clean, line 4 dirty but invalid, line 6 valid+dirty with ack in the same cycle (d=0) -> write-back only on idx 6; flush_done in cycle 18; wb_count=1.
- flush_req pulsed again in cycle 5 of a sweep, and spurious wb_ack in IDLE -> the first sweep completes (flush_done in cycle 17); a second full sweep starts in cycle 18 with stall continuously high; the ack in IDLE has no effect.
- rst_n asserted while in WRITEBACK on idx 2 -> wb_req, stall and busy drop immediately; wb_count=0, line_idx=0; after reset release with no flush_req, the FSM stays in IDLE.
